// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer: FSM states, unity gain and accumulator sizing.
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2
  } state_t;

  function automatic int unity_gain(input int gain_bits);
    return 2 ** (gain_bits - 1);
  endfunction

  // Wide enough that NUM_CH full-scale products at maximum gain cannot overflow.
  function automatic int acc_width(input int num_ch, input int data_bits, input int gain_bits);
    return data_bits + gain_bits + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Mixer channel/control bundle: master drives samples and strobe, slave is the mixer.
interface voice_mixer_if #(
  parameter int NUM_CH    = 4,
  parameter int DATA_BITS = 12,
  parameter int GAIN_BITS = 4
);
  logic                          sample_strobe;
  logic [NUM_CH*DATA_BITS-1:0]   ch_data;
  logic [NUM_CH*GAIN_BITS-1:0]   ch_gain;
  logic [NUM_CH-1:0]             ch_mute;
  logic [DATA_BITS-1:0]          dout;
  logic                          dout_valid;
  logic                          busy;
  logic                          clip;
  logic                          overrun;

  modport master (
    output sample_strobe, ch_data, ch_gain, ch_mute,
    input  dout, dout_valid, busy, clip, overrun
  );

  modport slave (
    input  sample_strobe, ch_data, ch_gain, ch_mute,
    output dout, dout_valid, busy, clip, overrun
  );
endinterface

// File: rtl/voice_mixer_sat_clip.sv
// Combinational signed clamp from IN_BITS to OUT_BITS with a clipped flag.
module sat_clip #(
  parameter int IN_BITS  = 21,
  parameter int OUT_BITS = 12
) (
  input  logic signed [IN_BITS-1:0]  din,
  output logic signed [OUT_BITS-1:0] dout,
  output logic                       clipped
);
  localparam logic [OUT_BITS-1:0] MAX_VAL = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0] MIN_VAL = {1'b1, {(OUT_BITS-1){1'b0}}};

  logic [IN_BITS-OUT_BITS:0] upper;

  always_comb begin
    upper   = din[IN_BITS-1:OUT_BITS-1];
    // In range only when every bit above the output sign bit matches it.
    clipped = (upper != '0) && (upper != '1);
    if (clipped) begin
      dout = din[IN_BITS-1] ? MIN_VAL : MAX_VAL;
    end else begin
      dout = din[OUT_BITS-1:0];
    end
  end
endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed N-channel mixer: snapshot, one gain MAC per clock, saturate.
// Define VOICE_MIXER_OFFSET_EN for offset-binary dout (MSB inverted) to drive pdm_dac.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_BITS = 12,
  parameter int GAIN_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  voice_mixer_if.slave   mix
);
  localparam int ACC_W  = acc_width(NUM_CH, DATA_BITS, GAIN_BITS);
  localparam int PROD_W = DATA_BITS + GAIN_BITS + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef VOICE_MIXER_OFFSET_EN
  localparam logic [DATA_BITS-1:0] DOUT_RST = {1'b1, {(DATA_BITS-1){1'b0}}};
`else
  localparam logic [DATA_BITS-1:0] DOUT_RST = '0;
`endif

  state_t                         state, state_next;
  logic                           load, mac, sat_en;
  logic [NUM_CH*DATA_BITS-1:0]    data_q;
  logic [NUM_CH*GAIN_BITS-1:0]    gain_q;
  logic [NUM_CH-1:0]              mute_q;
  logic [IDX_W-1:0]               idx;
  logic signed [ACC_W-1:0]        acc;
  logic signed [DATA_BITS-1:0]    data_sel;
  logic signed [GAIN_BITS:0]      gain_ext;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        term;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [DATA_BITS-1:0]    sat_val;
  logic                           sat_clipped;
  logic [DATA_BITS-1:0]           dout_fmt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (mix.sample_strobe) state_next = ST_ACCUM;
      ST_ACCUM: if (idx == IDX_W'(NUM_CH - 1)) state_next = ST_SAT;
      ST_SAT:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load        = (state == ST_IDLE) && mix.sample_strobe;
    mac         = (state == ST_ACCUM);
    sat_en      = (state == ST_SAT);
    mix.busy    = (state != ST_IDLE);
    mix.overrun = (state != ST_IDLE) && mix.sample_strobe;
  end

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    data_sel = data_q[idx*DATA_BITS +: DATA_BITS];
    gain_ext = {1'b0, gain_q[idx*GAIN_BITS +: GAIN_BITS]};
    prod     = PROD_W'(data_sel) * PROD_W'(gain_ext);
    term     = '0;
    if (!mute_q[idx]) term = ACC_W'(prod);
    shifted  = acc >>> (GAIN_BITS - 1);
  end

  sat_clip #(
    .IN_BITS (ACC_W),
    .OUT_BITS(DATA_BITS)
  ) u_sat_clip (
    .din    (shifted),
    .dout   (sat_val),
    .clipped(sat_clipped)
  );

  always_comb begin
`ifdef VOICE_MIXER_OFFSET_EN
    dout_fmt = {~sat_val[DATA_BITS-1], sat_val[DATA_BITS-2:0]};
`else
    dout_fmt = sat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q         <= '0;
      gain_q         <= '0;
      mute_q         <= '0;
      idx            <= '0;
      acc            <= '0;
      mix.dout       <= DOUT_RST;
      mix.dout_valid <= 1'b0;
      mix.clip       <= 1'b0;
    end else begin
      mix.dout_valid <= 1'b0;
      mix.clip       <= 1'b0;
      if (load) begin
        data_q <= mix.ch_data;
        gain_q <= mix.ch_gain;
        mute_q <= mix.ch_mute;
        idx    <= '0;
        acc    <= '0;
      end
      if (mac) begin
        acc <= acc + term;
        idx <= idx + IDX_W'(1);
      end
      if (sat_en) begin
        mix.dout       <= dout_fmt;
        mix.dout_valid <= 1'b1;
        mix.clip       <= sat_clipped;
      end
    end
  end
endmodule
